// File: rtl/mod_updown_counter_if.sv
// Control and status bundle for mod_updown_counter. The master drives the
// load/enable/direction/compare controls; the slave (the counter) returns the
// count, ripple carry, compare match and sticky wrap flag.
interface mod_updown_counter_if #(
    parameter int unsigned WIDTH = 4
) ();

    logic             LOAD_n;
    logic             ENP;
    logic             ENT;
    logic             UP;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] CMP;
    logic             WRAP_CLR;
    logic [WIDTH-1:0] Q;
    logic             RCO;
    logic             MATCH;
    logic             WRAP;

    modport master (
        output LOAD_n,
        output ENP,
        output ENT,
        output UP,
        output D,
        output CMP,
        output WRAP_CLR,
        input  Q,
        input  RCO,
        input  MATCH,
        input  WRAP
    );

    modport slave (
        input  LOAD_n,
        input  ENP,
        input  ENT,
        input  UP,
        input  D,
        input  CMP,
        input  WRAP_CLR,
        output Q,
        output RCO,
        output MATCH,
        output WRAP
    );

endinterface

// File: rtl/mod_updown_counter.sv
// Modulo-N up/down counter with clamped parallel load, compare match, ripple
// carry/borrow for cascading and a sticky wrap flag.
module mod_updown_counter #(
    parameter int unsigned     WIDTH   = 4,
    parameter longint unsigned MODULUS = 16
) (
    input  logic                CLK,
    input  logic                CLR,
    mod_updown_counter_if.slave io_bus
);

    // Elaboration-time parameter legality checks.
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("mod_updown_counter: WIDTH must be in 2..32");
    end
    if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
        $error("mod_updown_counter: MODULUS must be in 2..2**WIDTH");
    end
    if ($bits(io_bus.Q) != WIDTH) begin : g_bad_if_width
        $error("mod_updown_counter: interface WIDTH does not match counter WIDTH");
    end

    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 64'd1);

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;

    logic             w_at_max;
    logic             w_at_zero;
    logic             w_count_en;
    logic [WIDTH-1:0] w_load_val;
    logic [WIDTH-1:0] w_q_next;
    logic             w_wrap_evt;
    logic             w_wrap_next;

    assign w_at_max   = (r_q == MaxVal);
    assign w_at_zero  = (r_q == '0);
    assign w_count_en = io_bus.ENP & io_bus.ENT;
    // Out-of-range load values saturate at the top of the count range.
    assign w_load_val = (io_bus.D > MaxVal) ? MaxVal : io_bus.D;

    // Next count and wrap event: load beats count, count beats hold.
    always_comb begin
        w_q_next   = r_q;
        w_wrap_evt = 1'b0;
        if (!io_bus.LOAD_n) begin
            w_q_next = w_load_val;
        end else if (w_count_en) begin
            if (io_bus.UP) begin
                if (w_at_max) begin
                    w_q_next   = '0;
                    w_wrap_evt = 1'b1;
                end else begin
                    w_q_next = r_q + WIDTH'(1);
                end
            end else begin
                if (w_at_zero) begin
                    w_q_next   = MaxVal;
                    w_wrap_evt = 1'b1;
                end else begin
                    w_q_next = r_q - WIDTH'(1);
                end
            end
        end
    end

    // Sticky wrap: a wrap event wins over a simultaneous clear request.
    always_comb begin
        w_wrap_next = r_wrap;
        if (w_wrap_evt) begin
            w_wrap_next = 1'b1;
        end else if (io_bus.WRAP_CLR) begin
            w_wrap_next = 1'b0;
        end
    end

    // State registers with synchronous active-high clear.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_q    <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_q    <= w_q_next;
            r_wrap <= w_wrap_next;
        end
    end

    assign io_bus.Q     = r_q;
    assign io_bus.WRAP  = r_wrap;
    // Carry/borrow depends only on current count, direction and ENT.
    assign io_bus.RCO   = io_bus.ENT & ((io_bus.UP & w_at_max) | (~io_bus.UP & w_at_zero));
    // A compare value outside the count range can never match.
    assign io_bus.MATCH = (io_bus.CMP <= MaxVal) && (r_q == io_bus.CMP);

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed self-checking bench for mod_updown_counter: a WIDTH=4/MODULUS=10
// instance plus a two-stage MODULUS=16 cascade forming an 8-bit counter.
module tb_mod_updown_counter;

    logic clk;
    logic clr;
    int   checks;
    int   errors;

    mod_updown_counter_if #(.WIDTH(4)) b ();
    mod_updown_counter_if #(.WIDTH(4)) blo ();
    mod_updown_counter_if #(.WIDTH(4)) bhi ();

    mod_updown_counter #(.WIDTH(4), .MODULUS(10)) u_dut (
        .CLK    (clk),
        .CLR    (clr),
        .io_bus (b)
    );

    mod_updown_counter #(.WIDTH(4), .MODULUS(16)) u_lo (
        .CLK    (clk),
        .CLR    (clr),
        .io_bus (blo)
    );

    mod_updown_counter #(.WIDTH(4), .MODULUS(16)) u_hi (
        .CLK    (clk),
        .CLR    (clr),
        .io_bus (bhi)
    );

    // Cascade: low-stage carry feeds high-stage trickle enable.
    assign bhi.ENT = blo.RCO;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int up_q[12];
        up_q = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
        checks = 0;
        errors = 0;

        clr        = 1'b1;
        b.LOAD_n   = 1'b1;
        b.ENP      = 1'b0;
        b.ENT      = 1'b0;
        b.UP       = 1'b1;
        b.D        = 4'd0;
        b.CMP      = 4'd0;
        b.WRAP_CLR = 1'b0;
        blo.LOAD_n = 1'b1;
        blo.ENP    = 1'b0;
        blo.ENT    = 1'b1;
        blo.UP     = 1'b1;
        blo.D      = 4'd0;
        blo.CMP    = 4'd0;
        blo.WRAP_CLR = 1'b0;
        bhi.LOAD_n = 1'b1;
        bhi.ENP    = 1'b0;
        bhi.UP     = 1'b1;
        bhi.D      = 4'd0;
        bhi.CMP    = 4'd0;
        bhi.WRAP_CLR = 1'b0;

        // Reset state.
        step();
        clr = 1'b0;
        #1;
        chk("reset_q", 32'(b.Q), 32'd0);
        chk("reset_wrap", 32'(b.WRAP), 32'd0);
        chk("reset_match_cmp0", 32'(b.MATCH), 32'd1);
        chk("reset_rco_ent0", 32'(b.RCO), 32'd0);
        b.ENT = 1'b1;
        b.UP  = 1'b0;
        #1;
        chk("reset_rco_down", 32'(b.RCO), 32'd1);

        // Count up 12 edges: 1..9,0,1,2; wrap on 9->0.
        b.UP  = 1'b1;
        b.ENP = 1'b1;
        #1;
        chk("up_rco_at0", 32'(b.RCO), 32'd0);
        for (int i = 0; i < 12; i++) begin
            step();
            chk("up_q", 32'(b.Q), 32'(up_q[i]));
            chk("up_rco", 32'(b.RCO), (up_q[i] == 9) ? 32'd1 : 32'd0);
            chk("up_wrap", 32'(b.WRAP), (i >= 9) ? 32'd1 : 32'd0);
        end

        // Clear mid-count, then count down from 0: 9,8,7.
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_mid_q", 32'(b.Q), 32'd0);
        chk("clr_mid_wrap", 32'(b.WRAP), 32'd0);
        b.UP = 1'b0;
        #1;
        chk("down_rco_at0", 32'(b.RCO), 32'd1);
        step();
        chk("down_q9", 32'(b.Q), 32'd9);
        chk("down_wrap", 32'(b.WRAP), 32'd1);
        chk("down_rco_at9", 32'(b.RCO), 32'd0);
        step();
        chk("down_q8", 32'(b.Q), 32'd8);
        step();
        chk("down_q7", 32'(b.Q), 32'd7);

        // WRAP_CLR on a non-wrap edge clears; load never sets WRAP.
        b.ENP      = 1'b0;
        b.WRAP_CLR = 1'b1;
        step();
        b.WRAP_CLR = 1'b0;
        chk("wclr_wrap", 32'(b.WRAP), 32'd0);
        chk("wclr_hold_q", 32'(b.Q), 32'd7);
        b.LOAD_n = 1'b0;
        b.D      = 4'd13;
        step();
        chk("load_clamp", 32'(b.Q), 32'd9);
        chk("load_no_wrap", 32'(b.WRAP), 32'd0);
        b.D   = 4'd5;
        b.ENP = 1'b1;
        b.UP  = 1'b1;
        step();
        chk("load_beats_count", 32'(b.Q), 32'd5);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_beats_load", 32'(b.Q), 32'd0);

        // RCO and MATCH at Q=9 with ENP off.
        b.ENP = 1'b0;
        b.D   = 4'd9;
        step();
        b.LOAD_n = 1'b1;
        chk("load9", 32'(b.Q), 32'd9);
        chk("rco_q9_up", 32'(b.RCO), 32'd1);
        step();
        chk("hold_enp0", 32'(b.Q), 32'd9);
        b.ENT = 1'b0;
        #1;
        chk("rco_ent0", 32'(b.RCO), 32'd0);
        b.CMP = 4'd9;
        #1;
        chk("match_9", 32'(b.MATCH), 32'd1);
        b.CMP = 4'd12;
        #1;
        chk("match_12_q9", 32'(b.MATCH), 32'd0);
        b.ENT = 1'b1;
        b.ENP = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("match_12_sweep", 32'(b.MATCH), 32'd0);
        end
        chk("sweep_q", 32'(b.Q), 32'd9);
        chk("sweep_wrap", 32'(b.WRAP), 32'd1);

        // Set beats simultaneous WRAP_CLR; next non-wrap edge clears.
        b.WRAP_CLR = 1'b1;
        step();
        chk("setwins_q", 32'(b.Q), 32'd0);
        chk("setwins_wrap", 32'(b.WRAP), 32'd1);
        step();
        chk("clr_next_q", 32'(b.Q), 32'd1);
        chk("clr_next_wrap", 32'(b.WRAP), 32'd0);
        b.WRAP_CLR = 1'b0;

        // Direction change takes effect on the very next edge.
        b.UP = 1'b0;
        step();
        chk("dir_down", 32'(b.Q), 32'd0);
        b.UP = 1'b1;
        step();
        chk("dir_up", 32'(b.Q), 32'd1);

        // Two-stage cascade: 256 edges walk 0x00..0xFF and back to 0x00.
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("casc_reset", 32'({bhi.Q, blo.Q}), 32'd0);
        blo.ENP = 1'b1;
        bhi.ENP = 1'b1;
        for (int i = 1; i <= 256; i++) begin
            step();
            chk("casc_q", 32'({bhi.Q, blo.Q}), 32'(i % 256));
            chk("casc_hi_wrap", 32'(bhi.WRAP), (i == 256) ? 32'd1 : 32'd0);
        end
        blo.ENP = 1'b0;
        bhi.ENP = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
